// File: rtl/game_pkg.sv
// Shared encodings and limits for the reaction-game blocks.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2,
    DONE = 2'd3
  } sched_state_t;

  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam int          MAX_SECONDS = 63;
  localparam int          MAX_TARGETS = 8;

endpackage

// File: rtl/target_lfsr.sv
// 16-bit right-shifting Galois LFSR; load_n low reloads the seed on the clock edge.
module target_lfsr
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       load_n,
  output logic [2:0] pick
);

  logic [15:0] lfsr_reg;

  always_ff @(posedge clk) begin
    if (!load_n) begin
      lfsr_reg <= SEED;
    end else begin
      lfsr_reg <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  // Only the low bits feed target selection.
  assign pick = lfsr_reg[2:0];

endmodule

// File: rtl/target_scheduler.sv
// Lights pseudo-random targets, judges presses as hit or miss and runs the round countdown.
module target_scheduler
  import game_pkg::*;
#(
  parameter int          NUM_TARGETS   = 4,
  parameter int          GAME_SECONDS  = 30,
  parameter int          WINDOW_CYCLES = 75_000_000,
  parameter int          GAP_CYCLES    = 25_000_000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                   clkIn,
  input  logic                   reset,
  input  logic                   tick_1hz,
  input  logic                   game_active,
  input  logic [NUM_TARGETS-1:0] buttons,
  output logic [NUM_TARGETS-1:0] target_led,
  output logic                   player_scored,
  output logic                   player_missed,
  output logic                   timer_expired,
  output logic [5:0]             seconds_left
);

  localparam int              MAX_CYC      = (WINDOW_CYCLES > GAP_CYCLES) ? WINDOW_CYCLES : GAP_CYCLES;
  localparam int              CW           = $clog2(MAX_CYC);
  localparam logic [CW-1:0]   WINDOW_LOAD  = CW'(WINDOW_CYCLES - 1);
  localparam logic [CW-1:0]   GAP_LOAD     = CW'(GAP_CYCLES - 1);
  localparam logic [5:0]      SECONDS_INIT = 6'(GAME_SECONDS);
  localparam logic [3:0]      NT           = 4'(NUM_TARGETS);

  sched_state_t           state_reg;
  logic [CW-1:0]          count_reg;
  logic [NUM_TARGETS-1:0] btn_prev_reg;
  logic [NUM_TARGETS-1:0] press;
  logic [NUM_TARGETS-1:0] onehot;
  logic [2:0]             prev_idx_reg;
  logic [2:0]             lfsr_pick;
  logic [3:0]             raw_idx;
  logic [3:0]             sel_idx;
  logic                   hit_lit;
  logic                   hit_other;
  logic                   round_end;

  target_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clkIn),
    .load_n (reset),
    .pick   (lfsr_pick)
  );

  assign press     = buttons & ~btn_prev_reg;
  assign hit_other = |(press & ~target_led);
  assign hit_lit   = |(press & target_led);
  assign round_end = tick_1hz && (seconds_left == 6'd1);

  // Never repeat the previous target: bump to the next index instead.
  always_comb begin
    raw_idx = {1'b0, lfsr_pick} % NT;
    sel_idx = raw_idx;
    if (raw_idx == {1'b0, prev_idx_reg}) begin
      sel_idx = (raw_idx == NT - 4'd1) ? 4'd0 : raw_idx + 4'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_onehot
    assign onehot[gi] = (sel_idx == 4'(gi));
  end

  always_ff @(posedge clkIn) begin
    if (!reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      btn_prev_reg  <= '1;
      prev_idx_reg  <= 3'd0;
      target_led    <= '0;
      player_scored <= 1'b0;
      player_missed <= 1'b0;
      timer_expired <= 1'b0;
      seconds_left  <= SECONDS_INIT;
    end else begin
      btn_prev_reg  <= buttons;
      player_scored <= 1'b0;
      player_missed <= 1'b0;
      case (state_reg)
        IDLE: begin
          target_led    <= '0;
          timer_expired <= 1'b0;
          seconds_left  <= SECONDS_INIT;
          if (game_active) begin
            state_reg <= GAP;
            count_reg <= GAP_LOAD;
          end
        end
        GAP, SHOW: begin
          if (!game_active) begin
            state_reg    <= IDLE;
            target_led   <= '0;
            seconds_left <= SECONDS_INIT;
          end else if (round_end) begin
            // Round end wins over any judgement made in the same cycle.
            state_reg     <= DONE;
            timer_expired <= 1'b1;
            target_led    <= '0;
            seconds_left  <= 6'd0;
          end else begin
            if (tick_1hz && seconds_left != 6'd0) begin
              seconds_left <= seconds_left - 6'd1;
            end
            if (state_reg == GAP) begin
              if (count_reg == '0) begin
                state_reg    <= SHOW;
                target_led   <= onehot;
                prev_idx_reg <= sel_idx[2:0];
                count_reg    <= WINDOW_LOAD;
              end else begin
                count_reg <= count_reg - 1'b1;
              end
            end else begin
              if (hit_other || (!hit_lit && count_reg == '0)) begin
                player_missed <= 1'b1;
                target_led    <= '0;
                state_reg     <= GAP;
                count_reg     <= GAP_LOAD;
              end else if (hit_lit) begin
                player_scored <= 1'b1;
                target_led    <= '0;
                state_reg     <= GAP;
                count_reg     <= GAP_LOAD;
              end else begin
                count_reg <= count_reg - 1'b1;
              end
            end
          end
        end
        DONE: begin
          target_led   <= '0;
          seconds_left <= 6'd0;
          if (!game_active) begin
            state_reg     <= IDLE;
            timer_expired <= 1'b0;
            seconds_left  <= SECONDS_INIT;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_target_scheduler.sv
// Directed bench for target_scheduler with a shadow LFSR to predict which target lights.
module tb_target_scheduler;

  localparam int          NT   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       active = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic [3:0] led;
  logic       scored, missed, expired;
  logic [5:0] secs;

  always #5 clk = ~clk;

  target_scheduler #(
    .NUM_TARGETS   (NT),
    .GAME_SECONDS  (3),
    .WINDOW_CYCLES (8),
    .GAP_CYCLES    (4),
    .LFSR_SEED     (SEED)
  ) dut (
    .clkIn         (clk),
    .reset         (rst_n),
    .tick_1hz      (tick),
    .game_active   (active),
    .buttons       (btn),
    .target_led    (led),
    .player_scored (scored),
    .player_missed (missed),
    .timer_expired (expired),
    .seconds_left  (secs)
  );

  int errors = 0;
  int checks = 0;

  // Shadow LFSR: m_prev holds the value the DUT used at the most recent edge.
  logic [15:0] m_lfsr = SEED;
  logic [15:0] m_prev = SEED;
  always @(posedge clk) begin
    m_prev <= m_lfsr;
    m_lfsr <= !rst_n ? SEED : ({1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000));
  end

  logic [3:0] last_led = 4'b0000;
  bit         have_prev = 1'b0;
  int         prev_idx = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] outs();
    return {led, scored, missed, expired, secs};
  endfunction

  // One clock; whenever a target lights, check it against the predicted pick.
  task automatic step();
    int exp_idx;
    @(posedge clk);
    #1;
    if (last_led == 4'b0000 && led != 4'b0000) begin
      exp_idx = int'(m_prev[2:0]) % NT;
      if (have_prev) begin
        if (exp_idx == prev_idx) exp_idx = (exp_idx + 1) % NT;
        check("target_pick", 32'(led), 32'(1 << exp_idx));
      end else begin
        check("target_onehot", 32'($countones(led)), 32'(1));
      end
      for (int i = 0; i < NT; i++) if (led[i]) prev_idx = i;
      have_prev = 1'b1;
    end
    last_led = led;
  endtask

  task automatic wait_lit(input string tag, input int budget);
    int n;
    n = 0;
    while (led == 4'b0000 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_lit_wait"}, 32'(led != 4'b0000), 32'(1));
  endtask

  initial begin
    logic [3:0] lit;
    bit found;

    // 1: reset and idle
    step();
    step();
    check("reset_vals", 32'(outs()), 32'({4'b0, 1'b0, 1'b0, 1'b0, 6'd3}));
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_vals", 32'(outs()), 32'({4'b0, 1'b0, 1'b0, 1'b0, 6'd3}));
    end

    // 2: first target after the gap, then a hit
    active = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_gap_dark", 32'(led), 32'(0));
    end
    step();
    check("t2_lit", 32'(led != 4'b0000), 32'(1));
    lit = led;
    btn = led;
    step();
    check("t2_hit_pulse", 32'({led, scored, missed}), 32'({4'b0, 1'b1, 1'b0}));
    btn = 4'b0000;
    step();
    check("t2_hit_one_cycle", 32'({scored, missed}), 32'(2'b00));
    for (int i = 0; i < 2; i++) begin
      step();
      check("t2_gap2_dark", 32'(led), 32'(0));
    end
    step();
    check("t2_next_lit", 32'(led != 4'b0000), 32'(1));
    check("t2_next_differs", 32'(led != lit), 32'(1));

    // 3: timeout miss after 8 lit cycles, then wrong+right press together
    lit = led;
    for (int i = 0; i < 7; i++) begin
      step();
      check("t3_window", 32'({led, scored, missed}), 32'({lit, 1'b0, 1'b0}));
    end
    step();
    check("t3_timeout_miss", 32'({led, scored, missed}), 32'({4'b0, 1'b0, 1'b1}));
    step();
    check("t3_miss_one_cycle", 32'({scored, missed}), 32'(2'b00));
    wait_lit("t3", 20);
    btn = led | {led[2:0], led[3]};
    step();
    check("t3_multi_miss", 32'({led, scored, missed}), 32'({4'b0, 1'b0, 1'b1}));
    btn = 4'b0000;
    step();
    check("t3_multi_one_cycle", 32'({scored, missed}), 32'(2'b00));

    // 4: countdown; last tick coincides with a lit-button press
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("t4_secs2", 32'(secs), 32'(2));
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("t4_secs1", 32'(secs), 32'(1));
    wait_lit("t4", 20);
    btn  = led;
    tick = 1'b1;
    step();
    tick = 1'b0;
    btn  = 4'b0000;
    check("t4_round_end", 32'(outs()), 32'({4'b0, 1'b0, 1'b0, 1'b1, 6'd0}));
    tick = 1'b1;
    btn  = 4'b1111;
    step();
    tick = 1'b0;
    btn  = 4'b0000;
    check("t4_done_ignores", 32'(outs()), 32'({4'b0, 1'b0, 1'b0, 1'b1, 6'd0}));
    active = 1'b0;
    step();
    check("t4_back_idle", 32'(outs()), 32'({4'b0, 1'b0, 1'b0, 1'b0, 6'd3}));

    // 5: button 0 held through reset release must not count until re-pressed
    btn = 4'b0001;
    rst_n = 1'b0;
    have_prev = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    active = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 30 && !found; t++) begin
      wait_lit("t5", 50);
      if (led == 4'b0001) begin
        found = 1'b1;
      end else begin
        for (int c = 0; c < 7; c++) begin
          step();
          check("t5_held_no_pulse", 32'({scored, missed}), 32'(2'b00));
        end
        step();
        check("t5_timeout_miss", 32'({scored, missed}), 32'(2'b01));
      end
    end
    check("t5_target0_seen", 32'(found), 32'(1));
    if (found) begin
      for (int i = 0; i < 3; i++) begin
        step();
        check("t5_held_target0", 32'({led, scored, missed}), 32'({4'b0001, 1'b0, 1'b0}));
      end
      btn = 4'b0000;
      step();
      btn = 4'b0001;
      step();
      check("t5_repress_hit", 32'({led, scored, missed}), 32'({4'b0, 1'b1, 1'b0}));
    end
    btn = 4'b0000;

    // 6: one-edge reset mid-window, then restart from the gap
    wait_lit("t6", 50);
    step();
    step();
    rst_n = 1'b0;
    have_prev = 1'b0;
    step();
    check("t6_reset_vals", 32'(outs()), 32'({4'b0, 1'b0, 1'b0, 1'b0, 6'd3}));
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_restart_dark", 32'({led, scored, missed}), 32'(0));
    end
    step();
    check("t6_restart_lit", 32'(led != 4'b0000), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
